// File: rtl/mos_diag_collector_if.sv
// mos_diag_collector_if
// Bundles the upstream burst strobe/data, the back-pressured output stream and
// the sticky overflow flag of the diagonal-sum collector.
//   in_valid, in_data          : upstream burst (engine cannot stall)
//   out_valid, out_ready       : output valid/ready handshake
//   out_data, out_last         : output word, trailer marker
//   out_len_err                : trailer flag for a burst length other than 7/15
//   ovf                        : sticky dropped-input flag
// master: the side that produces input and consumes output (engine + consumer)
// slave : the collector itself
interface mos_diag_collector_if #(
    parameter int W = 40
) ();
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_len_err;
    logic         ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, out_len_err, ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, out_len_err, ovf
    );
endinterface

// File: rtl/mos_diag_collector.sv
// mos_diag_collector
// Captures one burst of signed anti-diagonal sums (nominally 7 or 15 words),
// then replays it to a back-pressured consumer followed by a trailer word
// holding the burst's signed maximum. Input arriving while the block cannot
// accept it is dropped and recorded in the sticky ovf flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mos_diag_collector_if.slave (input burst, output stream, ovf)
// Parameters:
//   DEPTH : buffer entries, maximum accepted burst length
//   W     : data width, signed two's complement
module mos_diag_collector #(
    parameter int DEPTH = 15,
    parameter int W     = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mos_diag_collector_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   buf_r [DEPTH];
    logic [CW-1:0]  wr_cnt_r;
    logic [CW-1:0]  rd_ptr_r;
    logic [CW-1:0]  rd_ptr_nxt_s;
    logic [CW-1:0]  len_r;
    logic [CW-1:0]  len_nxt_s;
    logic           len_err_r;
    logic           len_err_nxt_s;
    logic [W-1:0]   max_r;
    logic           in_valid_d_r;
    // Cleared by reset, set once in_valid has been seen low: an in_valid that
    // is already high when reset releases belongs to a burst we never saw the
    // start of, so it must not open a new capture.
    logic           armed_r;
    logic           ovf_r;

    logic           start_s;
    logic           store_s;
    logic           drop_s;

    logic           out_valid_r;
    logic [W-1:0]   out_data_r;
    logic           out_last_r;
    logic           out_len_err_r;
    logic           out_valid_nxt_s;
    logic [W-1:0]   out_data_nxt_s;
    logic           out_last_nxt_s;
    logic           out_len_err_nxt_s;

    // Next-state, read pointer and input accept/drop decisions
    always_comb begin
        state_nxt_s   = state_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        len_nxt_s     = len_r;
        len_err_nxt_s = len_err_r;
        start_s       = 1'b0;
        store_s       = 1'b0;
        drop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && armed_r && !in_valid_d_r) begin
                    start_s     = 1'b1;
                    state_nxt_s = COLLECT;
                end else if (bus.in_valid && armed_r) begin
                    // Still-high tail of a burst that was dropped earlier.
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    if (wr_cnt_r < CW'(DEPTH)) begin
                        store_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    state_nxt_s   = SEND;
                    len_nxt_s     = wr_cnt_r;
                    len_err_nxt_s = (wr_cnt_r != CW'(7)) && (wr_cnt_r != CW'(15));
                    rd_ptr_nxt_s  = {CW{1'b0}};
                end
            end
            SEND: begin
                drop_s = bus.in_valid;
                if (out_valid_r && bus.out_ready) begin
                    if (out_last_r) begin
                        state_nxt_s  = IDLE;
                        rd_ptr_nxt_s = {CW{1'b0}};
                    end else begin
                        rd_ptr_nxt_s = rd_ptr_r + CW'(1);
                    end
                end else begin
                    rd_ptr_nxt_s = rd_ptr_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output word for the next cycle, computed from next-state values so the
    // registered outputs line up with the state they describe
    always_comb begin
        out_valid_nxt_s   = (state_nxt_s == SEND);
        out_last_nxt_s    = 1'b0;
        out_len_err_nxt_s = 1'b0;
        out_data_nxt_s    = {W{1'b0}};
        if (out_valid_nxt_s) begin
            if (rd_ptr_nxt_s == len_nxt_s) begin
                out_last_nxt_s    = 1'b1;
                out_len_err_nxt_s = len_err_nxt_s;
                out_data_nxt_s    = max_r;
            end else if (rd_ptr_nxt_s < CW'(DEPTH)) begin
                out_data_nxt_s = buf_r[rd_ptr_nxt_s];
            end else begin
                out_data_nxt_s = {W{1'b0}};
            end
        end else begin
            out_data_nxt_s = {W{1'b0}};
        end
    end

    // State, pointers, length latch and input edge tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rd_ptr_r     <= {CW{1'b0}};
            len_r        <= {CW{1'b0}};
            len_err_r    <= 1'b0;
            in_valid_d_r <= 1'b0;
            armed_r      <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            len_r        <= len_nxt_s;
            len_err_r    <= len_err_nxt_s;
            in_valid_d_r <= bus.in_valid;
            if (!bus.in_valid) begin
                armed_r <= 1'b1;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Burst buffer, write count and running signed maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= {W{1'b0}};
            end
            wr_cnt_r <= {CW{1'b0}};
            max_r    <= {W{1'b0}};
        end else if (start_s) begin
            buf_r[0] <= bus.in_data;
            wr_cnt_r <= CW'(1);
            max_r    <= bus.in_data;
        end else if (store_s) begin
            buf_r[wr_cnt_r] <= bus.in_data;
            wr_cnt_r        <= wr_cnt_r + CW'(1);
            // Strict compare: on a tie the earlier word is kept.
            if ($signed(bus.in_data) > $signed(max_r)) begin
                max_r <= bus.in_data;
            end
        end
    end

    // Registered output stage; holds naturally while stalled because the
    // next-state values do not move without a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= {W{1'b0}};
            out_last_r    <= 1'b0;
            out_len_err_r <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_nxt_s;
            out_data_r    <= out_data_nxt_s;
            out_last_r    <= out_last_nxt_s;
            out_len_err_r <= out_len_err_nxt_s;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_last    = out_last_r;
    assign bus.out_len_err = out_len_err_r;
    assign bus.ovf         = ovf_r;

endmodule

// File: tb/tb_mos_diag_collector.sv
// tb_mos_diag_collector
// Directed bench for mos_diag_collector: nominal 4x4 and 8x8 bursts,
// backpressure hold, overflow, collision with a stalled drain, short burst
// length error and asynchronous reset in the middle of a drain.
module tb_mos_diag_collector;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mos_diag_collector_if #(.W(40)) bus ();

    mos_diag_collector #(.DEPTH(15), .W(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [39:0] got_d [$];
    logic        got_l [$];
    logic        got_e [$];

    // Drive a burst with in_valid high for consecutive cycles, then drop it.
    task automatic send_burst(input logic [39:0] v [$]);
        for (int i = 0; i < v.size(); i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 40'h0;
    endtask

    // Record accepted output words until the trailer; called at a negedge.
    // mode 0: out_ready held 1; mode 1: ready follows 1,0,0,1,0,0,...
    task automatic drain(input int budget, input int mode);
        got_d.delete(); got_l.delete(); got_e.delete();
        for (int c = 0; c < budget; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                got_e.push_back(bus.out_len_err);
                if (bus.out_last) break;
            end
            @(posedge clk); #1;
            bus.out_ready = (mode == 0) ? 1'b1 : (((c + 1) % 3) == 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 40'h0;
        bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 40'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
        checks++; if (bus.out_len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err: got %b expected 0", bus.out_len_err); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_4x4();
        logic [39:0] q [$];
        logic [39:0] exp [$];
        q = '{40'd1, 40'hFF_FFFF_FFFE, 40'd3, 40'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFB, 40'd6, 40'd0};
        exp = q;
        exp.push_back(40'h7F_FFFF_FFFF);
        bus.out_ready = 1'b1;
        send_burst(q);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL 4x4_lat_early: got out_valid %b expected 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 40'd1) begin errors++; $display("FAIL 4x4_lat_first: got %b/%h expected 1/%h", bus.out_valid, bus.out_data, 40'd1); end
        drain(40, 0);
        checks++; if (got_d.size() != 8) begin errors++; $display("FAIL 4x4_count: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL 4x4_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL 4x4_ovf: got %b expected 0", bus.ovf); end
    endtask

    task automatic test_8x8();
        logic [39:0] q [$];
        logic [39:0] exp [$];
        logic signed [39:0] t;
        for (int i = 0; i < 15; i++) begin
            t = -(i + 2);
            if (i == 3 || i == 9) t = 40'hFF_FFFF_FFFF;
            q.push_back(t);
        end
        exp = q;
        exp.push_back(40'hFF_FFFF_FFFF);
        bus.out_ready = 1'b1;
        send_burst(q);
        @(negedge clk);
        drain(40, 0);
        checks++; if (got_d.size() != 16) begin errors++; $display("FAIL 8x8_count: got %0d expected 16", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 15) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL 8x8_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] q [$];
        logic [39:0] exp [$];
        logic [39:0] pd;
        logic        pl, pe, stalled, done;
        q = '{40'd10, 40'd11, 40'd12, 40'd13, 40'd14, 40'd15, 40'd16};
        exp = q;
        exp.push_back(40'd16);
        got_d.delete(); got_l.delete(); got_e.delete();
        stalled = 1'b0; done = 1'b0; pd = 40'h0; pl = 1'b0; pe = 1'b0;
        bus.out_ready = 1'b1;
        send_burst(q);
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            bus.out_ready = ((c % 3) == 0);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (bus.out_data !== pd || bus.out_last !== pl || bus.out_len_err !== pe || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_hold: got %h expected %h", bus.out_data, pd);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pl = bus.out_last; pe = bus.out_len_err;
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                got_e.push_back(bus.out_len_err);
                if (bus.out_last) done = 1'b1;
            end
        end
        bus.out_ready = 1'b1;
        checks++; if (done !== 1'b1 || got_d.size() != 8) begin errors++; $display("FAIL bp_count: got %0d words expected 8", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL bp_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b expected 0", bus.ovf); end
    endtask

    task automatic test_overflow();
        logic [39:0] q [$];
        logic [39:0] exp [$];
        for (int i = 0; i < 15; i++) q.push_back(40'(i + 1));
        q.push_back(40'd100);
        q.push_back(40'd200);
        for (int i = 0; i < 15; i++) exp.push_back(40'(i + 1));
        exp.push_back(40'd15);
        bus.out_ready = 1'b1;
        send_burst(q);
        @(negedge clk);
        drain(40, 0);
        checks++; if (got_d.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 15) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf); end
    endtask

    task automatic test_collision();
        logic [39:0] a [$];
        logic [39:0] b [$];
        logic [39:0] c [$];
        logic [39:0] exp [$];
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL col_ovf_clear: got %b expected 0", bus.ovf); end
        a = '{40'd1, 40'd2, 40'd3, 40'd4, 40'd5, 40'd6, 40'd7};
        for (int i = 0; i < 15; i++) b.push_back(40'(1000 + i));
        bus.out_ready = 1'b0;
        send_burst(a);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 40'd1) begin errors++; $display("FAIL col_stalled: got %b/%h expected 1/%h", bus.out_valid, bus.out_data, 40'd1); end
        fork
            send_burst(b);
            begin
                repeat (2) @(posedge clk);
                #1; bus.out_ready = 1'b1;
                @(negedge clk);
                drain(40, 0);
            end
        join
        exp = a;
        exp.push_back(40'd7);
        checks++; if (got_d.size() != 8) begin errors++; $display("FAIL col_count: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL col_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL col_ovf: got %b expected 1", bus.ovf); end
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL col_tail_ignored: got out_valid %b expected 0", bus.out_valid); end
        c = '{40'd5, 40'hFF_FFFF_FFFD, 40'd9, 40'd9, 40'hFF_FFFF_FF9C, 40'd2, 40'd0};
        exp = c;
        exp.push_back(40'd9);
        send_burst(c);
        @(negedge clk);
        drain(40, 0);
        checks++; if (got_d.size() != 8) begin errors++; $display("FAIL col_clean_count: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL col_clean_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
    endtask

    task automatic test_short_and_reset();
        logic [39:0] q [$];
        logic [39:0] exp [$];
        q = '{40'd4, 40'hFF_FFFF_FFF8, 40'd2};
        exp = q;
        exp.push_back(40'd4);
        bus.out_ready = 1'b1;
        send_burst(q);
        @(negedge clk);
        drain(40, 0);
        checks++; if (got_d.size() != 4) begin errors++; $display("FAIL short_count: got %0d expected 4", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 3) || got_e[i] !== (i == 3)) begin
                errors++; $display("FAIL short_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        // Stall a drain, then pull reset between clock edges.
        q = '{40'd21, 40'd22, 40'd23, 40'd24, 40'd25, 40'd26, 40'd27};
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send_burst(q);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 40'd21) begin errors++; $display("FAIL rst_mid_pre: got %b/%h expected 1/%h", bus.out_valid, bus.out_data, 40'd21); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 40'h0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got %b/%h expected 0/%h", bus.out_valid, bus.out_data, 40'h0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        q = '{40'd7, 40'd6, 40'd5, 40'd4, 40'd3, 40'd2, 40'd1};
        exp = q;
        exp.push_back(40'd7);
        bus.out_ready = 1'b1;
        send_burst(q);
        @(negedge clk);
        drain(40, 0);
        checks++; if (got_d.size() != 8) begin errors++; $display("FAIL post_rst_count: got %0d expected 8", got_d.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] !== (i == 7) || got_e[i] !== 1'b0) begin
                errors++; $display("FAIL post_rst_word%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 40'h0, exp[i]);
            end
        end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL post_rst_ovf: got %b expected 0", bus.ovf); end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_8x8();
        test_backpressure();
        test_overflow();
        test_collision();
        test_short_and_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
